// File: rtl/cnt_sched_pkg.sv
// cnt_sched_pkg: shared types, default sizes and arbitration helpers for the
// shared-counter scheduler (cnt_sched, cnt_sched_rr_arb).
// The CNT_SCHED_FIXED_PRIO_EN build uses fixed_pick; the default build uses rr_pick.
package cnt_sched_pkg;

    localparam int NREQ_DEF = 4;
    localparam int CW_DEF   = 4;
    // Widest requester vector the helper functions accept
    localparam int NREQ_MAX = 8;

    // Scheduler states; the fourth code is illegal and recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Rotating priority: search upward from (ptr+1) mod nreq with wrap and
    // return the first requesting index (0 when nothing is requesting).
    function automatic int rr_pick(input logic [NREQ_MAX-1:0] req_vec,
                                   input int ptr, input int nreq);
        int   res;
        int   idx;
        logic found;
        res   = 0;
        idx   = 0;
        found = 1'b0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            if (k <= nreq) begin
                idx = (ptr + k) % nreq;
                if (!found && req_vec[idx]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Fixed priority: lowest requesting index (0 when nothing is requesting)
    function automatic int fixed_pick(input logic [NREQ_MAX-1:0] req_vec,
                                      input int nreq);
        int res;
        res = 0;
        for (int k = NREQ_MAX - 1; k >= 0; k--) begin
            if (k < nreq && req_vec[k]) begin
                res = k;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cnt_sched_rr_arb.sv
// cnt_sched_rr_arb: combinational round-robin winner select plus the
// last-served pointer register. Not instantiated when the scheduler is built
// with CNT_SCHED_FIXED_PRIO_EN (fixed priority, pointer unused).
module cnt_sched_rr_arb
    import cnt_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [NREQ-1:0] req_i,
    input  logic            ptr_ld_i,
    input  logic [IW-1:0]   ptr_val_i,
    output logic [IW-1:0]   win_o
);

    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       ptr_d;
    logic [NREQ_MAX-1:0] req_ext;

    // Pointer moves to the last served requester on completion or abort
    always_comb begin
        ptr_d = ptr_q;
        if (ptr_ld_i) begin
            ptr_d = ptr_val_i;
        end
    end

    // Pointer register; reset to NREQ-1 so requester 0 is searched first
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= IW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Zero-extend requests to the helper function's fixed width
    always_comb begin
        req_ext            = '0;
        req_ext[NREQ-1:0]  = req_i;
    end

    assign win_o = IW'(rr_pick(req_ext, int'(ptr_q), NREQ));

endmodule

// File: rtl/cnt_sched.sv
// cnt_sched: shares one up-counter among NREQ requesters. A granted requester
// gets the counter run from 0 to its latched target, then a one-cycle done
// pulse. Dropping req mid-run aborts without done.
// Build option CNT_SCHED_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin; everything else is identical.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int CW   = CW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] tgt,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [CW-1:0]      cnt,
    output logic               hit,
    output logic [NREQ-1:0]    done
);

    localparam int IW = $clog2(NREQ);

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   tgt_q, tgt_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   pick;
    logic            any_req;
    logic            win_req;
    logic            hit_w;
    logic            ptr_ld;
    logic [CW-1:0]   tgt_arr [NREQ];

    // Unpack the flat target bus into per-requester slices
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_tgt
            assign tgt_arr[gi] = tgt[gi*CW +: CW];
        end
    endgenerate

`ifdef CNT_SCHED_FIXED_PRIO_EN
    // Fixed priority: lowest requesting index always wins
    always_comb begin
        logic [NREQ_MAX-1:0] req_ext;
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
        pick              = IW'(fixed_pick(req_ext, NREQ));
    end
`else
    cnt_sched_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .clk_i     (clk),
        .rst_ni    (reset),
        .req_i     (req),
        .ptr_ld_i  (ptr_ld),
        .ptr_val_i (win_q),
        .win_o     (pick)
    );
`endif

    assign any_req = |req;
    assign win_req = req[win_q];
    // Depends on registers only, so it is safe as an observation point
    assign hit_w   = (state_q == ST_RUN) && (cnt_q == tgt_q);

    // Next-state and datapath control for IDLE/RUN/DONE
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        win_d   = win_q;
        ptr_ld  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                cnt_d = '0;
                if (any_req) begin
                    state_d = ST_RUN;
                    win_d   = pick;
                    gnt_d   = NREQ'(1) << pick;
                    tgt_d   = tgt_arr[pick];
                end
            end
            ST_RUN: begin
                if (!win_req) begin
                    // A dropped request beats a simultaneous hit
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_ld  = 1'b1;
                end else if (hit_w) begin
                    state_d = ST_DONE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                ptr_ld  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            win_q   <= win_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign cnt  = cnt_q;
    assign hit  = hit_w;
    assign busy = (state_q == ST_RUN) || (state_q == ST_DONE);

    // Structural invariants of the scheduler outputs
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(gnt_q));
    a_done_in_done: assert property (@(posedge clk) disable iff (!reset)
        (done_q != '0) |-> (state_q == ST_DONE));
    a_cnt_bounded: assert property (@(posedge clk) disable iff (!reset)
        (state_q != ST_IDLE) |-> (cnt_q <= tgt_q));

endmodule

// File: tb/tb_cnt_sched.sv
// tb_cnt_sched: randomized self-checking bench for cnt_sched. A transaction
// model predicts the winner from the arbitration rule and the per-cycle
// counter trace from the latched target.
module tb_cnt_sched;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic               clk   = 1'b0;
    logic               reset = 1'b0;
    logic [NREQ-1:0]    req   = '0;
    logic [NREQ*CW-1:0] tgt   = '0;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [CW-1:0]      cnt;
    logic               hit;
    logic [NREQ-1:0]    done;

    int total = 0;
    int bad   = 0;
    int mptr  = NREQ - 1;

    cnt_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .tgt   (tgt),
        .gnt   (gnt),
        .busy  (busy),
        .cnt   (cnt),
        .hit   (hit),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Arbitration rule straight from the description
    function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
`ifdef CNT_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
`else
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
`endif
        return -1;
    endfunction

    // One transaction from IDLE: grant, T+1 RUN cycles, DONE, IDLE.
    // abort_at / rst_at >= 0 drop req / assert reset when cnt shows that value.
    task automatic run_txn(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] t,
                           input int abort_at, input int rst_at, input string tag);
        int              w;
        int              tv;
        logic [NREQ-1:0] oh;
        w  = model_pick(r, mptr);
        tv = int'(t[w*CW +: CW]);
        oh = NREQ'(1) << w;
        req = r;
        tgt = t;
        for (int k = 0; k <= tv; k++) begin
            @(negedge clk);
            total++; if (gnt !== oh) begin bad++; $display("FAIL %s k=%0d gnt got=%b exp=%b", tag, k, gnt, oh); end
            total++; if (cnt !== CW'(k)) begin bad++; $display("FAIL %s k=%0d cnt got=%0d exp=%0d", tag, k, cnt, k); end
            total++; if (hit !== (k == tv)) begin bad++; $display("FAIL %s k=%0d hit got=%b exp=%b", tag, k, hit, (k == tv)); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s k=%0d busy got=%b exp=1", tag, k, busy); end
            total++; if (done !== '0) begin bad++; $display("FAIL %s k=%0d done got=%b exp=0", tag, k, done); end
            // Targets are only sampled at grant, so scramble them mid-run
            tgt = (NREQ*CW)'($urandom());
            if (k == rst_at) begin
                #1 reset = 1'b0;
                #1;
                total++; if (gnt !== '0) begin bad++; $display("FAIL %s async_rst gnt got=%b exp=0", tag, gnt); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s async_rst busy got=%b exp=0", tag, busy); end
                total++; if (cnt !== '0) begin bad++; $display("FAIL %s async_rst cnt got=%0d exp=0", tag, cnt); end
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    total++; if (done !== '0 || gnt !== '0) begin bad++; $display("FAIL %s in_rst done=%b gnt=%b exp=0", tag, done, gnt); end
                end
                req   = '0;
                reset = 1'b1;
                mptr  = NREQ - 1;
                $display("txn %s: req=%b winner=%0d tgt=%0d reset at cnt=%0d", tag, r, w, tv, k);
                return;
            end
            if (k == abort_at) begin
                req = r & ~oh;
                @(negedge clk);
                total++; if (gnt !== '0) begin bad++; $display("FAIL %s abort gnt got=%b exp=0", tag, gnt); end
                total++; if (cnt !== '0) begin bad++; $display("FAIL %s abort cnt got=%0d exp=0", tag, cnt); end
                total++; if (done !== '0) begin bad++; $display("FAIL %s abort done got=%b exp=0", tag, done); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s abort busy got=%b exp=0", tag, busy); end
                mptr = w;
                req  = '0;
                $display("txn %s: req=%b winner=%0d tgt=%0d aborted at cnt=%0d", tag, r, w, tv, k);
                return;
            end
        end
        @(negedge clk);
        total++; if (done !== oh) begin bad++; $display("FAIL %s done_cyc done got=%b exp=%b", tag, done, oh); end
        total++; if (gnt !== '0) begin bad++; $display("FAIL %s done_cyc gnt got=%b exp=0", tag, gnt); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s done_cyc busy got=%b exp=1", tag, busy); end
        total++; if (cnt !== CW'(tv)) begin bad++; $display("FAIL %s done_cyc cnt got=%0d exp=%0d", tag, cnt, tv); end
        total++; if (hit !== 1'b0) begin bad++; $display("FAIL %s done_cyc hit got=%b exp=0", tag, hit); end
        mptr = w;
        @(negedge clk);
        total++; if (done !== '0) begin bad++; $display("FAIL %s idle done got=%b exp=0", tag, done); end
        total++; if (gnt !== '0 || busy !== 1'b0) begin bad++; $display("FAIL %s idle gnt=%b busy=%b exp=0/0", tag, gnt, busy); end
        total++; if (cnt !== '0) begin bad++; $display("FAIL %s idle cnt got=%0d exp=0", tag, cnt); end
        req = '0;
        $display("txn %s: req=%b winner=%0d tgt=%0d completed", tag, r, w, tv);
    endtask

    task automatic test_reset();
        logic [NREQ*CW-1:0] t;
        reset = 1'b0;
        req   = 4'b1111;
        repeat (3) @(negedge clk);
        total++; if (gnt !== '0) begin bad++; $display("FAIL reset gnt got=%b exp=0", gnt); end
        total++; if (cnt !== '0) begin bad++; $display("FAIL reset cnt got=%0d exp=0", cnt); end
        total++; if (done !== '0) begin bad++; $display("FAIL reset done got=%b exp=0", done); end
        total++; if (busy !== 1'b0 || hit !== 1'b0) begin bad++; $display("FAIL reset busy=%b hit=%b exp=0/0", busy, hit); end
        req   = '0;
        reset = 1'b1;
        mptr  = NREQ - 1;
        @(negedge clk);
        t = (NREQ*CW)'($urandom()) & 16'h3333;
        run_txn(4'b1111, t, -1, -1, "reset_first");
    endtask

    task automatic test_single();
        logic [NREQ*CW-1:0] t;
        t = (NREQ*CW)'($urandom());
        t[2*CW +: CW] = 4'd3;
        run_txn(4'b0100, t, -1, -1, "single");
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, '0, -1, -1, "round_robin");
        end
    endtask

    task automatic test_abort();
        logic [NREQ*CW-1:0] t;
        t = (NREQ*CW)'($urandom()) & 16'h1111;
        t[1*CW +: CW] = 4'd9;
        run_txn(4'b0010, t, 4, -1, "abort");
        run_txn(4'b0011, (NREQ*CW)'($urandom()) & 16'h3333, -1, -1, "after_abort");
    endtask

    task automatic test_boundary();
        logic [NREQ*CW-1:0] t;
        t = '1;
        run_txn(NREQ'(1) << $urandom_range(NREQ - 1, 0), t, -1, -1, "tgt_max");
        t = {NREQ{4'd5}};
        run_txn(4'b1000, t, 5, -1, "abort_at_hit");
    endtask

    task automatic test_async_reset();
        logic [NREQ*CW-1:0] t;
        t = (NREQ*CW)'($urandom());
        t[0 +: CW] = 4'd10;
        run_txn(4'b0001, t, -1, 5, "async_rst");
        run_txn(4'b1111, (NREQ*CW)'($urandom()) & 16'h3333, -1, -1, "post_rst");
    endtask

    task automatic test_random();
        logic [NREQ-1:0]    r;
        logic [NREQ*CW-1:0] t;
        int                 w;
        int                 tv;
        int                 ab;
        for (int i = 0; i < 40; i++) begin
            r  = NREQ'($urandom_range((1 << NREQ) - 1, 1));
            t  = (NREQ*CW)'($urandom());
            w  = model_pick(r, mptr);
            tv = int'(t[w*CW +: CW]);
            ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(tv, 0)) : -1;
            run_txn(r, t, ab, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_boundary();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
